// File: rtl/sid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sid_pkg
//  Description : Shared register map, FSM state encoding and saturation
//                helper for the SID voice mixing engine.
//  Revision    : 1.0  initial release
// ============================================================================
package sid_pkg;

    // Register map (5-bit address space)
    localparam logic [4:0] c_ADDR_ROUTE_LO = 5'h17;  // bits[2:0]: voices 0-2 to filter
    localparam logic [4:0] c_ADDR_MODE_VOL = 5'h18;  // bits[6:4]: HP/BP/LP, bits[3:0]: volume
    localparam logic [4:0] c_ADDR_ROUTE_HI = 5'h1D;  // bits[4:0]: voices 3-7 to filter

    // Term scaling: mdac-equivalent shift, then the per-voice mix shift
    localparam int c_MDAC_SHIFT = 4;
    localparam int c_MIX_SHIFT  = 3;

    localparam logic [3:0] c_VOL_RESET = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_MIX   = 3'd3,
        ST_VOL   = 3'd4
    } sid_state_e;

    // Clamp a signed value to the range of an out_w-bit signed number.
    function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                    input int                 out_w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
        lo = ~hi;
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_mix_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : sid_mix_engine_if
//  Description : Register write bus of the SID mixing engine (strobe,
//                address, data). The host drives it through the master
//                modport; the engine samples it through the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface sid_mix_engine_if;
    import sid_pkg::*;

    logic       WR;
    logic [4:0] ADDR;
    logic [7:0] DATAW;

    modport master (output WR, ADDR, DATAW);
    modport slave  (input  WR, ADDR, DATAW);

endinterface
`default_nettype wire

// File: rtl/sid_mdac_tm.sv
`default_nettype none
// ============================================================================
//  Module      : sid_mdac_tm
//  Description : Registered signed-by-unsigned multiplier shared by all
//                voices. The voice is offset-binary, so inverting its MSB
//                yields two's complement; the envelope is zero-extended.
//                Maps onto a single DSP multiplier with output register.
//  Revision    : 1.0  initial release
// ============================================================================
module sid_mdac_tm
    import sid_pkg::*;
#(
    parameter int VOICE_W = 12,
    parameter int ENV_W   = 8
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            i_en,
    input  logic [VOICE_W-1:0]              i_voice,
    input  logic [ENV_W-1:0]                i_env,
    output logic signed [VOICE_W+ENV_W:0]   o_prod
);

    localparam int c_PROD_W = VOICE_W + ENV_W + 1;

    logic signed [c_PROD_W-1:0] w_a;
    logic signed [c_PROD_W-1:0] w_b;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] r_prod;

    assign w_a    = c_PROD_W'($signed({~i_voice[VOICE_W-1], i_voice[VOICE_W-2:0]}));
    assign w_b    = c_PROD_W'($signed({1'b0, i_env}));
    assign w_prod = w_a * w_b;

    // Product register, loaded only while a voice is being issued
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_prod <= '0;
        end else if (i_en) begin
            r_prod <= w_prod;
        end
    end

    assign o_prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/sid_mix_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sid_mix_engine
//  Description : Per-sample voice mixer. On CLKen each voice is scaled by
//                its envelope through one shared multiplier, summed into a
//                filter or bypass accumulator, the filter bus is presented,
//                selected filter outputs are mixed back in and the result is
//                scaled by the master volume.
//  Revision    : 1.0  initial release
// ============================================================================
module sid_mix_engine
    import sid_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int VOICE_W    = 12,
    parameter int ENV_W      = 8,
    parameter int OUT_W      = 16
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            CLKen,
    sid_mix_engine_if.slave                 bus,
    input  logic [NUM_VOICES*VOICE_W-1:0]   VOICE_IN,
    input  logic [NUM_VOICES*ENV_W-1:0]     ENV_IN,
    input  logic signed [OUT_W-1:0]         FILT_LP,
    input  logic signed [OUT_W-1:0]         FILT_BP,
    input  logic signed [OUT_W-1:0]         FILT_HP,
    output logic signed [OUT_W-1:0]         PRE_FILTER,
    output logic signed [OUT_W-1:0]         OUTPUT,
    output logic                            OUT_VALID,
    output logic                            OVERRUN
);

    localparam int c_ACC_W  = OUT_W + 3;            // headroom for 8 full-scale terms
    localparam int c_SUM_W  = c_ACC_W + 2;          // bypass plus three filter outputs
    localparam int c_PROD_W = VOICE_W + ENV_W + 1;
    localparam int c_VP_W   = OUT_W + 4;            // sample x 4-bit volume
    localparam int c_IDX_W  = 4;                    // counts 0..NUM_VOICES

    logic                           r_rst_sync;
    logic                           w_rst_n;
    sid_state_e                     r_state;
    logic [c_IDX_W-1:0]             r_idx;
    logic [2:0]                     r_term_idx;
    logic                           r_prod_vld;
    logic [NUM_VOICES*VOICE_W-1:0]  r_voice;
    logic [NUM_VOICES*ENV_W-1:0]    r_env;
    logic signed [c_ACC_W-1:0]      r_acc_f;
    logic signed [c_ACC_W-1:0]      r_acc_b;
    logic signed [OUT_W-1:0]        r_post;
    logic signed [OUT_W-1:0]        r_pre_filter;
    logic signed [OUT_W-1:0]        r_output;
    logic                           r_out_valid;
    logic                           r_overrun;
    logic [7:0]                     r_route;
    logic [2:0]                     r_mode;
    logic [3:0]                     r_vol;

    logic [VOICE_W-1:0]             w_voice_sel;
    logic [ENV_W-1:0]               w_env_sel;
    logic signed [c_PROD_W-1:0]     w_prod;
    logic signed [c_ACC_W-1:0]      w_term;
    logic                           w_route_bit;
    logic                           w_mac_en;
    logic signed [c_ACC_W-1:0]      w_acc_f_next;
    logic signed [c_ACC_W-1:0]      w_acc_b_next;
    logic signed [c_SUM_W-1:0]      w_mix_sum;
    logic signed [c_VP_W-1:0]       w_vol_prod;
    logic                           w_unused_bits;

    // Reset asserts immediately; release waits for one CLK edge so the
    // second edge after release is the first that can start a sequence.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_sync <= 1'b1;
        end
    end

    assign w_rst_n = r_rst_sync;

    // Pick the snapshot slice for the voice currently being issued
    always_comb begin
        w_voice_sel = '0;
        w_env_sel   = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_voice_sel = r_voice[k*VOICE_W +: VOICE_W];
                w_env_sel   = r_env[k*ENV_W +: ENV_W];
            end
        end
    end

    assign w_mac_en = (r_state == ST_MAC);

    sid_mdac_tm #(
        .VOICE_W (VOICE_W),
        .ENV_W   (ENV_W)
    ) u_mdac (
        .CLK     (CLK),
        .RST_N   (w_rst_n),
        .i_en    (w_mac_en),
        .i_voice (w_voice_sel),
        .i_env   (w_env_sel),
        .o_prod  (w_prod)
    );

    assign w_term      = c_ACC_W'((w_prod >>> c_MDAC_SHIFT) >>> c_MIX_SHIFT);
    // Routing is read live, so a write lands on the next voice accumulated
    assign w_route_bit = r_route[r_term_idx];

    // Steer the pending term into one of the two accumulators
    always_comb begin
        w_acc_f_next = r_acc_f;
        w_acc_b_next = r_acc_b;
        if (r_prod_vld) begin
            if (w_route_bit) begin
                w_acc_f_next = r_acc_f + w_term;
            end else begin
                w_acc_b_next = r_acc_b + w_term;
            end
        end
    end

    // Bypass path plus whichever filter outputs the mode bits select
    always_comb begin
        w_mix_sum = c_SUM_W'(r_acc_b);
        if (r_mode[0]) begin
            w_mix_sum = w_mix_sum + c_SUM_W'(FILT_LP);
        end
        if (r_mode[1]) begin
            w_mix_sum = w_mix_sum + c_SUM_W'(FILT_BP);
        end
        if (r_mode[2]) begin
            w_mix_sum = w_mix_sum + c_SUM_W'(FILT_HP);
        end
    end

    assign w_vol_prod = c_VP_W'(r_post) * c_VP_W'($signed({1'b0, r_vol}));

    // Control registers; a write during a sequence applies from the next cycle
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_route <= '0;
            r_mode  <= '0;
            r_vol   <= c_VOL_RESET;
        end else if (bus.WR) begin
            case (bus.ADDR)
                c_ADDR_ROUTE_LO: r_route[2:0] <= bus.DATAW[2:0];
                c_ADDR_ROUTE_HI: r_route[7:3] <= bus.DATAW[4:0];
                c_ADDR_MODE_VOL: begin
                    r_mode <= bus.DATAW[6:4];
                    r_vol  <= bus.DATAW[3:0];
                end
                default: ;
            endcase
        end
    end

    // Sequencer: snapshot, pipelined multiply-accumulate, drain, mix, volume
    always_ff @(posedge CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_term_idx   <= '0;
            r_prod_vld   <= 1'b0;
            r_voice      <= '0;
            r_env        <= '0;
            r_acc_f      <= '0;
            r_acc_b      <= '0;
            r_post       <= '0;
            r_pre_filter <= '0;
            r_output     <= '0;
            r_out_valid  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_prod_vld  <= w_mac_en;
            if (CLKen && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (CLKen) begin
                        r_voice <= VOICE_IN;
                        r_env   <= ENV_IN;
                        r_acc_f <= '0;
                        r_acc_b <= '0;
                        r_idx   <= '0;
                        r_state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    r_acc_f    <= w_acc_f_next;
                    r_acc_b    <= w_acc_b_next;
                    r_term_idx <= r_idx[2:0];
                    r_idx      <= r_idx + 1'b1;
                    if (r_idx == c_IDX_W'(NUM_VOICES - 1)) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    r_acc_f      <= w_acc_f_next;
                    r_acc_b      <= w_acc_b_next;
                    r_pre_filter <= OUT_W'(saturate(32'(w_acc_f_next), OUT_W));
                    r_state      <= ST_MIX;
                end
                ST_MIX: begin
                    r_post  <= OUT_W'(saturate(32'(w_mix_sum), OUT_W));
                    r_state <= ST_VOL;
                end
                ST_VOL: begin
                    r_output    <= w_vol_prod[OUT_W+3:4];
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign PRE_FILTER = r_pre_filter;
    assign OUTPUT     = r_output;
    assign OUT_VALID  = r_out_valid;
    assign OVERRUN    = r_overrun;

    // DATAW bit 7 has no register behind it; volume fraction bits drop out
    assign w_unused_bits = &{1'b0, bus.DATAW[7], w_vol_prod[3:0]};

endmodule
`default_nettype wire

// File: doc/sid_mix_engine.md
SID_MIX_ENGINE -- requirements
Module: sid_mix_engine

Interface
REQ-001 SHALL take parameter NUM_VOICES, default 3; voice channel count, legal range 1..8.
REQ-002 SHALL take parameter VOICE_W, default 12; unsigned-offset oscillator width.
REQ-003 SHALL take parameter ENV_W, default 8; unsigned envelope width.
REQ-004 SHALL take parameter OUT_W, default 16; signed mix/output width.
REQ-005 SHALL have port CLK, input, 1 bit: master clock. One clock domain only.
REQ-006 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port CLKen, input, 1 bit: 1 MHz sample enable, which starts a mix sequence.
REQ-008 SHALL have port WR, input, 1 bit: register write strobe.
REQ-009 SHALL have port ADDR, input, 5 bits: register address.
REQ-010 SHALL have port DATAW, input, 8 bits: write data.
REQ-011 SHALL have port VOICE_IN, input, NUM_VOICES*VOICE_W bits: voice k in slice k.
REQ-012 SHALL have port ENV_IN, input, NUM_VOICES*ENV_W bits: envelope k in slice k.
REQ-013 SHALL have ports FILT_LP, FILT_BP and FILT_HP, inputs, OUT_W bits each: signed filter outputs.
REQ-014 SHALL have port PRE_FILTER, output, OUT_W bits: signed filter input bus.
REQ-015 SHALL have port OUTPUT, output, OUT_W bits: signed final sample.
REQ-016 SHALL have port OUT_VALID, output, 1 bit: one-cycle pulse when OUTPUT updates.
REQ-017 SHALL have port OVERRUN, output, 1 bit: sticky flag; CLKen arrived while busy.

Function
REQ-018 Registers, written on WR: 0x17 bits[2:0] route voices 0-2 to the filter; 0x1D bits[4:0] route voices 3-7 (bits above NUM_VOICES ignored); 0x18 bits[6:4] select HP/BP/LP (bit6=HP, bit5=BP, bit4=LP); 0x18 bits[3:0] set volume.
REQ-019 FSM states: IDLE, MAC, DRAIN, MIX, VOL. It SHALL reset to IDLE.
REQ-020 IDLE + CLKen: snapshot VOICE_IN and ENV_IN, clear both accumulators, set idx=0, go to MAC.
REQ-021 MAC: one registered multiply per cycle, signed(voice[idx], MSB inverted) x unsigned env[idx]; idx++ each cycle.
REQ-022 After N MAC cycles the FSM SHALL go to DRAIN.
REQ-023 Each product SHALL be accumulated one cycle after it is registered (pipelined), into the filter accumulator or the bypass accumulator according to that voice's route bit.
REQ-024 Term scaling: term = (product >>> 4) >>> 3, arithmetic; for the default widths this equals the 16-bit mdac result >>> 3.
REQ-025 Accumulators SHALL be OUT_W+3 bits, so no internal overflow occurs.
REQ-026 DRAIN: add the final term; PRE_FILTER <= saturate(filter accumulator to OUT_W); go to MIX.
REQ-027 MIX: post = saturate(bypass + the selected FILT_LP/BP/HP inputs).
REQ-028 MIX inputs SHALL be sampled in the MIX cycle; the FSM then goes to VOL.
REQ-029 VOL: OUTPUT <= (post x volume) >>> 4, signed; OUT_VALID=1 for exactly this one cycle; return to IDLE.
REQ-030 Latency: OUTPUT and OUT_VALID update on the clock edge N+3 cycles after the CLKen cycle; PRE_FILTER updates at edge N+1.
REQ-031 Saturation SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-032 CLKen in any state other than IDLE SHALL be ignored and SHALL set OVERRUN=1; OVERRUN is cleared only by reset.
REQ-033 A register write during a sequence SHALL take effect in the cycle after the write; routing SHALL be sampled per voice as that voice's term is accumulated.
REQ-034 WR and CLKen in the same cycle: the write SHALL commit and the sequence SHALL start; there is no conflict between them.
REQ-035 OUTPUT and PRE_FILTER SHALL hold their values between sequences.

Reset
REQ-036 RST_N low, in any state: FSM=IDLE; idx, accumulators, PRE_FILTER, OUTPUT, OUT_VALID and OVERRUN all 0.
REQ-037 RST_N low: volume=0xF, routing=0, mode=0.
REQ-038 Reset mid-sequence SHALL abort the sequence with no OUT_VALID pulse.
REQ-039 Deassertion SHALL be synchronised to CLK; the first CLKen is accepted from the 2nd edge after release.

Structure
REQ-040 Package sid_pkg SHALL hold register addresses (0x17, 0x18, 0x1D), FSM state enum, and the saturate function.
REQ-041 Sub-module sid_mdac_tm SHALL implement the registered signed-by-unsigned multiply (SB_MAC16-mappable), instantiated once and time-multiplexed.

Verification
REQ-042 N=3, vol=F, route=0, mode=0; voice0=0xFFF env0=0xFF, others 0x800 -> OUTPUT=3823, OUT_VALID at CLKen+6.
REQ-043 Voice0=0x000, env0=0xFF, all else as REQ-042 -> OUTPUT=-3825.
REQ-044 Route voice0 to filter (0x17=0x01), voice0=0xFFF env0=0xFF, mode=0 -> PRE_FILTER=4078, OUTPUT=0.
REQ-045 N=8, all voices 0xFFF env 0xFF, route=0, mode=LP, FILT_LP=0x7FFF -> post saturates to 32767; OUTPUT=30719.
REQ-046 Second CLKen 2 cycles after the first -> ignored; OVERRUN=1; exactly one OUT_VALID pulse.
REQ-047 RST_N low during MAC -> OUTPUT=0, no OUT_VALID; afterwards volume reads 0xF, so REQ-042 reproduces 3823.
